// File: rtl/timer_pkg.sv
// Shared housekeeping-timer definitions used by system_timer and msecond_watchdog.
package timer_pkg;

  // Milliseconds per second, shared with system_timer's rollover logic.
  localparam int MS_PER_S = 1000;

  // Watchdog state encoding. These values are visible on the state port.
  typedef enum logic [1:0] {
    WDT_IDLE    = 2'd0,
    WDT_RUN     = 2'd1,
    WDT_WARN    = 2'd2,
    WDT_EXPIRED = 2'd3
  } wdt_state_t;

endpackage

// File: rtl/msecond_watchdog.sv
// Millisecond watchdog driven by system_timer's msecond_pulse.
// It counts down from a programmable period and raises warn near the deadline.
// If it is not kicked in time, it latches expired and pulses reset_req once.
module msecond_watchdog
  import timer_pkg::*;
#(
  parameter int TIMEOUT_MS = 1000,
  parameter int WARN_MS    = 100,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msecond_pulse,
  input  logic             enable,
  input  logic             kick,
  input  logic             load,
  input  logic [CNT_W-1:0] period_in,
  output logic [CNT_W-1:0] remaining,
  output logic             warn,
  output logic             expired,
  output logic             reset_req,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] WARN_C    = CNT_W'(WARN_MS);
  localparam logic [CNT_W-1:0] ZERO_C    = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  wdt_state_t       state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             warn_q, warn_d;
  logic             expired_q, expired_d;
  logic             reset_req_q, reset_req_d;

  // A zero period would expire immediately on arming, so it is stored as 1 ms.
  logic [CNT_W-1:0] load_val_s;
  // Saturating decrement, so remaining can never wrap below zero.
  logic [CNT_W-1:0] dec_val_s;

  // Operand preparation for the next-state logic.
  always_comb begin
    load_val_s = (period_in == ZERO_C) ? ONE_C : period_in;
    dec_val_s  = (remaining_q == ZERO_C) ? ZERO_C : (remaining_q - ONE_C);
  end

  // Next-state, counter and flag logic.
  // In RUN and WARN, the priority per cycle is disable > kick > ms tick.
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    remaining_d = remaining_q;
    case (state_q)
      WDT_IDLE: begin
        if (load) begin
          period_d    = load_val_s;
          remaining_d = load_val_s;
        end else begin
          remaining_d = period_q;
        end
        if (enable) begin
          remaining_d = period_d;
          state_d     = (period_d <= WARN_C) ? WDT_WARN : WDT_RUN;
        end else begin
          state_d = WDT_IDLE;
        end
      end
      WDT_RUN, WDT_WARN: begin
        if (!enable) begin
          state_d     = WDT_IDLE;
          remaining_d = period_q;
        end else if (kick) begin
          // A kick wins over a coincident ms tick: reload, no decrement.
          remaining_d = period_q;
          state_d     = (period_q <= WARN_C) ? WDT_WARN : WDT_RUN;
        end else if (msecond_pulse) begin
          remaining_d = dec_val_s;
          if (dec_val_s == ZERO_C) begin
            state_d = WDT_EXPIRED;
          end else if (dec_val_s <= WARN_C) begin
            state_d = WDT_WARN;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      WDT_EXPIRED: begin
        // Only disabling leaves EXPIRED. There is no auto re-arm while enable stays high.
        if (!enable) begin
          state_d     = WDT_IDLE;
          remaining_d = period_q;
        end else begin
          remaining_d = ZERO_C;
        end
      end
      default: begin
        state_d     = WDT_IDLE;
        remaining_d = period_q;
      end
    endcase
    warn_d      = (state_d == WDT_WARN);
    expired_d   = (state_d == WDT_EXPIRED);
    reset_req_d = (state_d == WDT_EXPIRED) && (state_q != WDT_EXPIRED);
  end

  // State, counters and registered output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WDT_IDLE;
      period_q    <= TIMEOUT_C;
      remaining_q <= TIMEOUT_C;
      warn_q      <= 1'b0;
      expired_q   <= 1'b0;
      reset_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      remaining_q <= remaining_d;
      warn_q      <= warn_d;
      expired_q   <= expired_d;
      reset_req_q <= reset_req_d;
    end
  end

  assign remaining = remaining_q;
  assign warn      = warn_q;
  assign expired   = expired_q;
  assign reset_req = reset_req_q;
  assign state     = state_q;

endmodule

// File: tb/tb_msecond_watchdog.sv
// Testbench for msecond_watchdog.
// A directed sequence is followed by a random phase.
// Every cycle is compared against a millisecond-level reference model.
module tb_msecond_watchdog;

  localparam int W    = 2;
  localparam int TOUT = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msecond_pulse = 1'b0;
  logic        enable = 1'b0;
  logic        kick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] period_in = 16'd0;
  logic [15:0] remaining;
  logic        warn, expired, reset_req;
  logic [1:0]  dut_state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 idle, 1 counting, 2 counting near deadline, 3 expired.
  int m_mode, m_period, m_rem;
  bit m_req;

  msecond_watchdog #(.TIMEOUT_MS(TOUT), .WARN_MS(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .msecond_pulse(msecond_pulse), .enable(enable),
    .kick(kick), .load(load), .period_in(period_in), .remaining(remaining),
    .warn(warn), .expired(expired), .reset_req(reset_req), .state(dut_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int live_mode(int ms_left);
    return (ms_left <= W) ? 2 : 1;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_period = TOUT; m_rem = TOUT; m_req = 0;
  endfunction

  function automatic void model_step(bit p, bit en, bit k, bit ld, int pin);
    m_req = 0;
    case (m_mode)
      0: begin
        if (ld) begin m_period = (pin == 0) ? 1 : pin; m_rem = m_period; end
        if (en) begin m_rem = m_period; m_mode = live_mode(m_period); end
      end
      1, 2: begin
        if (!en) begin m_mode = 0; m_rem = m_period; end
        else if (k) begin m_rem = m_period; m_mode = live_mode(m_period); end
        else if (p) begin
          if (m_rem > 0) m_rem = m_rem - 1;
          if (m_rem == 0) begin m_mode = 3; m_req = 1; end
          else m_mode = live_mode(m_rem);
        end
      end
      default: begin
        if (!en) begin m_mode = 0; m_rem = m_period; end
      end
    endcase
  endfunction

  task automatic check_model();
    chk("state", 32'(dut_state), m_mode);
    chk("remaining", 32'(remaining), m_rem);
    chk("warn", 32'(warn), ((m_mode == 1 || m_mode == 2) && m_rem <= W) ? 1 : 0);
    chk("expired", 32'(expired), (m_mode == 3) ? 1 : 0);
    chk("reset_req", 32'(reset_req), m_req ? 1 : 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(dut_state), 0);
    chk({tag, "_remaining"}, 32'(remaining), TOUT);
    chk({tag, "_warn"}, 32'(warn), 0);
    chk({tag, "_expired"}, 32'(expired), 0);
    chk({tag, "_reset_req"}, 32'(reset_req), 0);
  endtask

  // One clock: drive inputs 1 time unit after the edge, step the model at the edge,
  // then check outputs 1 time unit after the edge.
  task automatic cycle(input bit p, input bit en, input bit k, input bit ld, input int pin);
    msecond_pulse = p; enable = en; kick = k; load = ld; period_in = 16'(pin);
    @(posedge clk);
    model_step(p, en, k, ld, pin);
    #1;
    check_model();
  endtask

  // One millisecond: nine quiet clocks, then a clock carrying msecond_pulse.
  task automatic tick_ms(input bit en);
    repeat (9) cycle(1'b0, en, 1'b0, 1'b0, 0);
    cycle(1'b1, en, 1'b0, 1'b0, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // load 5 ms, arm; after 3 ms only 2 remain -> WARN
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 5);
    chk("load5_rem", 32'(remaining), 5);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("arm_state", 32'(dut_state), 1);
    repeat (3) tick_ms(1'b1);
    chk("warn_rem", 32'(remaining), 2);
    chk("warn_flag", 32'(warn), 1);
    chk("warn_state", 32'(dut_state), 2);

    // two more ms -> EXPIRED, reset_req for one cycle
    repeat (2) tick_ms(1'b1);
    chk("exp_state", 32'(dut_state), 3);
    chk("exp_req_first", 32'(reset_req), 1);
    chk("exp_rem", 32'(remaining), 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 9);
    chk("exp_req_second", 32'(reset_req), 0);
    chk("exp_sticky", 32'(expired), 1);
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("exp_no_rearm", 32'(dut_state), 3);

    // disable -> IDLE with period restored; rearm, count down to 3, kick+pulse
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("idle_rem", 32'(remaining), 5);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (2) tick_ms(1'b1);
    chk("pre_kick_rem", 32'(remaining), 3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("kick_rem", 32'(remaining), 5);
    chk("kick_state", 32'(dut_state), 1);

    // load while RUN is ignored
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 7);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("load_run_ignored", 32'(remaining), 5);

    // period 0 is stored as 1 -> immediate WARN, one ms to expiry
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("p0_rem", 32'(remaining), 1);
    chk("p0_state", 32'(dut_state), 2);
    tick_ms(1'b1);
    chk("p0_expired", 32'(dut_state), 3);

    // async reset in the middle of WARN
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 6);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (4) tick_ms(1'b1);
    chk("prereset_state", 32'(dut_state), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // random phase
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) != 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 8)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
